// File: rtl/cellram_arbiter_pkg.sv
// Shared definitions for the cellram arbiter: instruction codes, default field widths
// and the transaction state encoding.
package cellram_arbiter_pkg;

  localparam int DEF_NB      = 16;
  localparam int DEF_NB_ADDR = 23;
  localparam int DEF_NB_BL   = 6;
  localparam int DEF_NB_INST = 3;

  localparam logic [2:0] INSTR_WRITE = 3'b000;
  localparam logic [2:0] INSTR_READ  = 3'b001;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_DATA = 3'd1;
  localparam logic [2:0] ST_WR_CMD  = 3'd2;
  localparam logic [2:0] ST_RD_CMD  = 3'd3;
  localparam logic [2:0] ST_RD_DATA = 3'd4;

endpackage

// File: rtl/cellram_arbiter_rr.sv
// Combinational round-robin picker: grants the first requester at or above ptr, with wrap.
module rr_arbiter #(
  parameter  int N_REQ = 2,
  localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   grant_idx,
  output logic             grant_any
);

  int best_dist;

  // NOTE: every output of a combinational block gets a default first, otherwise
  // paths that skip an assignment infer a latch.
  always_comb begin
    best_dist = N_REQ;
    grant_idx = '0;
    // Distance from the pointer measured upward with wrap; the smallest wins.
    for (int j = 0; j < N_REQ; j++) begin
      if (req[j] && ((j + N_REQ - int'(ptr)) % N_REQ) < best_dist) begin
        best_dist = (j + N_REQ - int'(ptr)) % N_REQ;
        grant_idx = IDW'(j);
      end
    end
    grant_any = (best_dist < N_REQ);
    grant     = '0;
    for (int j = 0; j < N_REQ; j++) begin
      grant[j] = grant_any && (IDW'(j) == grant_idx);
    end
  end

endmodule

// File: rtl/cellram_arbiter.sv
// Shares one cellram_interface command/write/read FIFO port set among N_REQ requesters,
// one transaction at a time, round-robin.
module cellram_arbiter
  import cellram_arbiter_pkg::*;
#(
  parameter  int N_REQ   = 2,
  parameter  int Nb      = DEF_NB,
  parameter  int Nb_addr = DEF_NB_ADDR,
  parameter  int Nb_bl   = DEF_NB_BL,
  parameter  int Nb_inst = DEF_NB_INST,
  localparam int IDW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                       clk_core,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req_cmd_valid,
  output logic [N_REQ-1:0]           req_cmd_ready,
  input  logic [N_REQ*Nb_inst-1:0]   req_cmd_instr,
  input  logic [N_REQ*Nb_addr-1:0]   req_cmd_addr,
  input  logic [N_REQ*Nb_bl-1:0]     req_cmd_bl,
  input  logic [N_REQ*Nb-1:0]        req_wr_data,
  input  logic [N_REQ-1:0]           req_wr_valid,
  output logic [N_REQ-1:0]           req_wr_ready,
  output logic [Nb-1:0]              req_rd_data,
  output logic [N_REQ-1:0]           req_rd_valid,
  input  logic [N_REQ-1:0]           req_rd_ready,
  output logic [Nb_inst-1:0]         mem_cmd_instr,
  output logic [Nb_addr-1:0]         mem_cmd_addr,
  output logic [Nb_bl-1:0]           mem_cmd_bl,
  output logic                       mem_cmd_valid,
  input  logic                       mem_cmd_ready,
  output logic [Nb-1:0]              mem_wr_data,
  output logic                       mem_wr_valid,
  input  logic                       mem_wr_ready,
  input  logic [Nb-1:0]              mem_rd_data,
  input  logic                       mem_rd_valid,
  output logic                       mem_rd_ready,
  output logic                       busy,
  output logic [IDW-1:0]             grant_id
);

  localparam int CW = Nb_bl + 1;

  logic [2:0]         state;
  logic [IDW-1:0]     rr_ptr;
  logic [CW-1:0]      count;
  logic [N_REQ-1:0]   arb_req;
  logic [N_REQ-1:0]   arb_grant;
  logic [IDW-1:0]     arb_idx;
  logic               arb_any;
  logic [Nb_inst-1:0] sel_instr;
  logic [Nb_addr-1:0] sel_addr;
  logic [Nb_bl-1:0]   sel_bl;
  logic               wr_hs;
  logic               rd_hs;
  logic               last_word;

  assign arb_req = (state == ST_IDLE) ? req_cmd_valid : '0;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req       (arb_req),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_any (arb_any)
  );

  assign req_cmd_ready = arb_grant;
  assign sel_instr     = req_cmd_instr[int'(arb_idx)*Nb_inst +: Nb_inst];
  assign sel_addr      = req_cmd_addr[int'(arb_idx)*Nb_addr +: Nb_addr];
  assign sel_bl        = req_cmd_bl[int'(arb_idx)*Nb_bl +: Nb_bl];

  // The command port decodes registered state and latched fields only.
  assign mem_cmd_valid = (state == ST_WR_CMD) || (state == ST_RD_CMD);
  assign busy          = (state != ST_IDLE);

  assign wr_hs     = (state == ST_WR_DATA) && req_wr_valid[grant_id] && mem_wr_ready;
  assign rd_hs     = (state == ST_RD_DATA) && mem_rd_valid && req_rd_ready[grant_id];
  assign last_word = (count == {1'b0, mem_cmd_bl});

  // Data paths are pass-through for the owner only; everyone else sees zeros.
  always_comb begin
    mem_wr_valid = 1'b0;
    mem_wr_data  = '0;
    req_wr_ready = '0;
    mem_rd_ready = 1'b0;
    req_rd_valid = '0;
    req_rd_data  = '0;
    if (state == ST_WR_DATA) begin
      mem_wr_valid           = req_wr_valid[grant_id];
      mem_wr_data            = req_wr_data[int'(grant_id)*Nb +: Nb];
      req_wr_ready[grant_id] = mem_wr_ready;
    end
    if (state == ST_RD_DATA) begin
      mem_rd_ready           = req_rd_ready[grant_id];
      req_rd_valid[grant_id] = mem_rd_valid;
      req_rd_data            = mem_rd_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      grant_id      <= '0;
      count         <= '0;
      mem_cmd_instr <= '0;
      mem_cmd_addr  <= '0;
      mem_cmd_bl    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            mem_cmd_instr <= sel_instr;
            mem_cmd_addr  <= sel_addr;
            mem_cmd_bl    <= sel_bl;
            grant_id      <= arb_idx;
            rr_ptr        <= (arb_idx == IDW'(N_REQ - 1)) ? '0 : arb_idx + IDW'(1);
            count         <= '0;
            // Unknown instructions are consumed here and never reach the memory.
            if (sel_instr == Nb_inst'(INSTR_WRITE)) begin
              state <= ST_WR_DATA;
            end else if (sel_instr == Nb_inst'(INSTR_READ)) begin
              state <= ST_RD_CMD;
            end
          end
        end
        ST_WR_DATA: begin
          if (wr_hs) begin
            count <= count + CW'(1);
            if (last_word) state <= ST_WR_CMD;
          end
        end
        ST_WR_CMD: begin
          if (mem_cmd_ready) state <= ST_IDLE;
        end
        ST_RD_CMD: begin
          if (mem_cmd_ready) state <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          if (rd_hs) begin
            count <= count + CW'(1);
            if (last_word) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cellram_arbiter.sv
// Scoreboard bench for cellram_arbiter: requester drivers, a memory responder and a monitor
// that predicts grants, write words, commands and read data from a reference memory.
module tb_cellram_arbiter;

  localparam int N   = 2;
  localparam int NB  = 16;
  localparam int NA  = 23;
  localparam int NBL = 6;
  localparam int NI  = 3;
  localparam logic [2:0] WR = 3'b000;
  localparam logic [2:0] RD = 3'b001;

  logic clk_core = 1'b0;
  logic reset_n  = 1'b0;
  always #5 clk_core = ~clk_core;

  logic [N-1:0]    req_cmd_valid = '0;
  logic [N-1:0]    req_cmd_ready;
  logic [N*NI-1:0] req_cmd_instr = '0;
  logic [N*NA-1:0] req_cmd_addr  = '0;
  logic [N*NBL-1:0] req_cmd_bl   = '0;
  logic [N*NB-1:0] req_wr_data   = '0;
  logic [N-1:0]    req_wr_valid  = '0;
  logic [N-1:0]    req_wr_ready;
  logic [NB-1:0]   req_rd_data;
  logic [N-1:0]    req_rd_valid;
  logic [N-1:0]    req_rd_ready  = '0;
  logic [NI-1:0]   mem_cmd_instr;
  logic [NA-1:0]   mem_cmd_addr;
  logic [NBL-1:0]  mem_cmd_bl;
  logic            mem_cmd_valid;
  logic            mem_cmd_ready = 1'b0;
  logic [NB-1:0]   mem_wr_data;
  logic            mem_wr_valid;
  logic            mem_wr_ready  = 1'b0;
  logic [NB-1:0]   mem_rd_data   = '0;
  logic            mem_rd_valid  = 1'b0;
  logic            mem_rd_ready;
  logic            busy;
  logic [0:0]      grant_id;

  cellram_arbiter #(.N_REQ(N), .Nb(NB), .Nb_addr(NA), .Nb_bl(NBL), .Nb_inst(NI)) dut (
    .clk_core      (clk_core),
    .reset_n       (reset_n),
    .req_cmd_valid (req_cmd_valid),
    .req_cmd_ready (req_cmd_ready),
    .req_cmd_instr (req_cmd_instr),
    .req_cmd_addr  (req_cmd_addr),
    .req_cmd_bl    (req_cmd_bl),
    .req_wr_data   (req_wr_data),
    .req_wr_valid  (req_wr_valid),
    .req_wr_ready  (req_wr_ready),
    .req_rd_data   (req_rd_data),
    .req_rd_valid  (req_rd_valid),
    .req_rd_ready  (req_rd_ready),
    .mem_cmd_instr (mem_cmd_instr),
    .mem_cmd_addr  (mem_cmd_addr),
    .mem_cmd_bl    (mem_cmd_bl),
    .mem_cmd_valid (mem_cmd_valid),
    .mem_cmd_ready (mem_cmd_ready),
    .mem_wr_data   (mem_wr_data),
    .mem_wr_valid  (mem_wr_valid),
    .mem_wr_ready  (mem_wr_ready),
    .mem_rd_data   (mem_rd_data),
    .mem_rd_valid  (mem_rd_valid),
    .mem_rd_ready  (mem_rd_ready),
    .busy          (busy),
    .grant_id      (grant_id)
  );

  typedef struct {
    logic [2:0]     instr;
    logic [NA-1:0]  addr;
    logic [NBL-1:0] bl;
    int             owner;
  } cmd_t;

  typedef struct {
    int            owner;
    logic [NB-1:0] data;
    bit            last;
  } rd_t;

  int n_vec = 0;
  int n_bad = 0;
  int wr_stall = 0;
  int rd_stall = 0;

  logic [NB-1:0] pay [N][$];
  logic [NB-1:0] exp_wr [$];
  cmd_t          exp_cmd [$];
  rd_t           exp_rd [$];
  int            grant_log [$];
  logic [NB-1:0] ref_mem [int];
  logic [NB-1:0] sim_mem [int];
  logic [NB-1:0] wfifo [$];
  logic [NB-1:0] rfifo [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input string why);
    n_vec++;
    n_bad++;
    $display("FAIL %s: %s (t=%0t)", name, why, $time);
  endtask

  function automatic int key(input logic [NA-1:0] a, input int k);
    return (int'(a) + k) & 32'h007F_FFFF;
  endfunction

  function automatic logic [NB-1:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  // Round-robin rule: first valid requester at or above the pointer, wrapping.
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // ---------------- memory responder (stand-in for cellram_interface) ----------------
  initial begin
    forever begin
      @(negedge clk_core);
      if (!reset_n) begin
        wfifo.delete();
        rfifo.delete();
      end else begin
        if (mem_wr_valid && mem_wr_ready) wfifo.push_back(mem_wr_data);
        if (mem_rd_valid && mem_rd_ready) void'(rfifo.pop_front());
        if (mem_cmd_valid && mem_cmd_ready) begin
          if (mem_cmd_instr == WR) begin
            foreach (wfifo[k]) sim_mem[key(mem_cmd_addr, k)] = wfifo[k];
            wfifo.delete();
          end else if (mem_cmd_instr == RD) begin
            for (int k = 0; k <= int'(mem_cmd_bl); k++)
              rfifo.push_back(sim_mem.exists(key(mem_cmd_addr, k)) ? sim_mem[key(mem_cmd_addr, k)] : '0);
          end
        end
      end
      @(posedge clk_core);
      #1;
      mem_cmd_ready = ($urandom_range(99) < 70);
      mem_wr_ready  = ($urandom_range(99) < 75);
      mem_rd_valid  = (rfifo.size() > 0) && ($urandom_range(99) < 75);
      mem_rd_data   = (rfifo.size() > 0) ? rfifo[0] : '0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int             m_ptr = 0;
  bit             m_busy = 0;
  bit             m_cmd_due = 0;
  int             m_owner = 0;
  int             m_wr_left = 0;
  logic [NB-1:0]  pend_words [$];
  logic [N-1:0]   own;
  logic [2:0]     ci;
  logic [NA-1:0]  ca;
  logic [NBL-1:0] cb;
  int             g;
  cmd_t           c;
  rd_t            r;

  initial begin
    forever begin
      @(negedge clk_core);
      if (!reset_n) begin
        exp_wr.delete();
        exp_cmd.delete();
        exp_rd.delete();
        pend_words.delete();
        m_ptr = 0;
        m_busy = 0;
        m_cmd_due = 0;
      end else begin
        check("busy", busy, m_busy);
        if (m_cmd_due) begin
          check("cmd_latency", mem_cmd_valid, 1);
          m_cmd_due = 0;
        end
        own = m_busy ? N'(1 << m_owner) : '0;
        check("non_owner", (req_wr_ready | req_rd_valid) & ~own, 0);
        check("rd_hs_match", mem_rd_valid && mem_rd_ready, |(req_rd_valid & req_rd_ready));

        if (req_cmd_ready != '0) begin
          g = pick(req_cmd_valid, m_ptr);
          check("grant", req_cmd_ready, (g < 0) ? 0 : (1 << g));
          check("accept_when_idle", m_busy, 0);
          if (g >= 0) begin
            m_ptr = (g + 1) % N;
            grant_log.push_back(g);
            ci = req_cmd_instr[g*NI +: NI];
            ca = req_cmd_addr[g*NA +: NA];
            cb = req_cmd_bl[g*NBL +: NBL];
            if (ci == WR) begin
              exp_cmd.push_back('{ci, ca, cb, g});
              pend_words = pay[g];
              foreach (pend_words[k]) exp_wr.push_back(pend_words[k]);
              m_wr_left = int'(cb) + 1;
              m_busy = 1;
              m_owner = g;
            end else if (ci == RD) begin
              exp_cmd.push_back('{ci, ca, cb, g});
              for (int k = 0; k <= int'(cb); k++)
                exp_rd.push_back('{g, ref_rd(key(ca, k)), (k == int'(cb))});
              m_busy = 1;
              m_owner = g;
              m_cmd_due = 1;
            end
          end
        end

        if (mem_wr_valid && mem_wr_ready) begin
          if (exp_wr.size() == 0) fail("wr_data", "unexpected write word");
          else check("wr_data", mem_wr_data, exp_wr.pop_front());
          m_wr_left--;
          if (m_wr_left == 0) m_cmd_due = 1;
        end

        if (mem_cmd_valid && mem_cmd_ready) begin
          if (exp_cmd.size() == 0) fail("cmd", "unexpected command");
          else begin
            c = exp_cmd.pop_front();
            check("cmd_instr", mem_cmd_instr, c.instr);
            check("cmd_addr", mem_cmd_addr, c.addr);
            check("cmd_bl", mem_cmd_bl, c.bl);
            check("cmd_owner", grant_id, c.owner);
            if (c.instr == WR) begin
              foreach (pend_words[k]) ref_mem[key(c.addr, k)] = pend_words[k];
              m_busy = 0;
            end
          end
        end

        if ((req_rd_valid & req_rd_ready) != '0) begin
          if (exp_rd.size() == 0) fail("rd_data", "unexpected read word");
          else begin
            r = exp_rd.pop_front();
            check("rd_owner", req_rd_valid, 1 << r.owner);
            check("rd_data", req_rd_data, r.data);
            if (r.last) m_busy = 0;
          end
        end
      end
    end
  end

  // ---------------- requester drivers ----------------
  task automatic send_cmd(input int i, input logic [2:0] instr, input logic [NA-1:0] addr,
                          input logic [NBL-1:0] bl, output bit ok);
    int t = 0;
    ok = 0;
    req_cmd_instr[i*NI +: NI]   = instr;
    req_cmd_addr[i*NA +: NA]    = addr;
    req_cmd_bl[i*NBL +: NBL]    = bl;
    req_cmd_valid[i]            = 1'b1;
    while (!ok && t < 4000) begin
      @(negedge clk_core);
      if (req_cmd_ready[i]) ok = 1;
      @(posedge clk_core);
      #1;
      t++;
    end
    req_cmd_valid[i] = 1'b0;
    if (!ok) fail("cmd_accept", $sformatf("requester %0d never granted", i));
  endtask

  task automatic feed_words(input int i, input logic [NB-1:0] w [$], input int n);
    int k = 0;
    int t = 0;
    while (k < n && t < 4000) begin
      req_wr_valid[i]            = ($urandom_range(99) >= wr_stall);
      req_wr_data[i*NB +: NB]    = w[k];
      @(negedge clk_core);
      if (req_wr_valid[i] && req_wr_ready[i]) k++;
      @(posedge clk_core);
      #1;
      t++;
    end
    req_wr_valid[i] = 1'b0;
    if (k < n) fail("wr_progress", $sformatf("requester %0d sent %0d of %0d words", i, k, n));
  endtask

  task automatic drain_rd(input int i, input int n);
    int k = 0;
    int t = 0;
    while (k < n && t < 4000) begin
      req_rd_ready[i] = ($urandom_range(99) >= rd_stall);
      @(negedge clk_core);
      if (req_rd_valid[i] && req_rd_ready[i]) k++;
      @(posedge clk_core);
      #1;
      t++;
    end
    req_rd_ready[i] = 1'b0;
    if (k < n) fail("rd_progress", $sformatf("requester %0d got %0d of %0d words", i, k, n));
  endtask

  task automatic txn(input int i, input logic [2:0] instr, input logic [NA-1:0] addr,
                     input logic [NBL-1:0] bl);
    logic [NB-1:0] w [$];
    bit ok;
    if (instr == WR) begin
      for (int k = 0; k <= int'(bl); k++) w.push_back(NB'($urandom));
      pay[i] = w;
    end
    send_cmd(i, instr, addr, bl, ok);
    if (ok && instr == WR) feed_words(i, w, int'(bl) + 1);
    if (ok && instr == RD) drain_rd(i, int'(bl) + 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || exp_wr.size() != 0 || exp_cmd.size() != 0 || exp_rd.size() != 0) && t < 5000) begin
      @(negedge clk_core);
      t++;
    end
    if (t >= 5000) fail("wait_idle", "arbiter did not return to idle");
    @(posedge clk_core);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk_core);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic rand_loop(input int i);
    int sel;
    logic [2:0] instr;
    repeat (8) begin
      sel   = $urandom_range(9);
      instr = (sel < 4) ? WR : (sel < 9) ? RD : 3'b110;
      txn(i, instr, NA'($urandom_range(63)), NBL'($urandom_range(15)));
      repeat ($urandom_range(3)) begin
        @(posedge clk_core);
        #1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int base;
  logic [NB-1:0] w5 [$];
  bit ok5;

  initial begin
    repeat (3) @(posedge clk_core);
    #1;
    reset_n = 1'b1;
    @(negedge clk_core);
    check("reset_handshakes", {req_cmd_ready, req_wr_ready, req_rd_valid, mem_cmd_valid,
                               mem_wr_valid, mem_rd_ready, busy}, 0);
    check("reset_cmd_fields", {mem_cmd_instr, mem_cmd_addr, mem_cmd_bl, grant_id}, 0);
    @(posedge clk_core);
    #1;

    // Single-word write then read back.
    txn(0, WR, 23'h0, 6'd0);
    txn(0, RD, 23'h0, 6'd0);
    wait_idle();

    // Simultaneous requests right after reset: requester 0 wins first.
    do_reset();
    base = grant_log.size();
    fork
      txn(0, WR, 23'h100, 6'd15);
      txn(1, WR, 23'h200, 6'd15);
    join
    wait_idle();
    check("t2_grants", grant_log.size() - base, 2);
    if (grant_log.size() - base == 2) begin
      check("t2_first", grant_log[base], 0);
      check("t2_second", grant_log[base+1], 1);
    end

    // Long read by requester 1 holds off requester 0.
    txn(0, WR, 23'hA0F2, 6'd21);
    wait_idle();
    base = grant_log.size();
    fork
      txn(1, RD, 23'hA0F2, 6'd21);
      begin
        @(posedge clk_core);
        #1;
        txn(0, WR, 23'h40, 6'd3);
      end
    join
    wait_idle();
    check("t3_grants", grant_log.size() - base, 2);
    if (grant_log.size() - base == 2) begin
      check("t3_first", grant_log[base], 1);
      check("t3_second", grant_log[base+1], 0);
    end

    // Maximum burst with stalls on both sides.
    wr_stall = 40;
    rd_stall = 40;
    txn(0, WR, 23'h1607, 6'd63);
    txn(0, RD, 23'h1607, 6'd63);
    wait_idle();

    // Reset in the middle of a write burst, then normal service resumes.
    wr_stall = 0;
    for (int k = 0; k < 19; k++) w5.push_back(NB'($urandom));
    pay[0] = w5;
    send_cmd(0, WR, 23'h300, 6'd18, ok5);
    feed_words(0, w5, 5);
    do_reset();
    @(negedge clk_core);
    check("t5_handshakes", {req_cmd_ready, req_wr_ready, req_rd_valid, mem_cmd_valid,
                            mem_wr_valid, mem_rd_ready, busy}, 0);
    check("t5_outputs", {mem_cmd_instr, mem_cmd_addr, mem_cmd_bl, grant_id, mem_wr_data, req_rd_data}, 0);
    @(posedge clk_core);
    #1;
    base = grant_log.size();
    txn(1, WR, 23'h310, 6'd2);
    txn(1, RD, 23'h310, 6'd2);
    wait_idle();
    check("t5_regrant", grant_log.size() - base, 2);

    // Unknown instruction is accepted and dropped.
    req_cmd_instr[0 +: NI] = 3'b111;
    req_cmd_addr[0 +: NA]  = 23'h55;
    req_cmd_bl[0 +: NBL]   = 6'd4;
    req_cmd_valid[0]       = 1'b1;
    @(negedge clk_core);
    check("t6_accept", req_cmd_ready, 2'b01);
    @(posedge clk_core);
    #1;
    req_cmd_valid[0] = 1'b0;
    @(negedge clk_core);
    check("t6_idle", {busy, mem_cmd_valid}, 0);
    @(posedge clk_core);
    #1;

    // Randomized concurrent traffic.
    wr_stall = 30;
    rd_stall = 30;
    fork
      rand_loop(0);
      rand_loop(1);
    join
    wait_idle();

    check("left_wr", exp_wr.size(), 0);
    check("left_cmd", exp_cmd.size(), 0);
    check("left_rd", exp_rd.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
